// File: rtl/census_disparity_wta_pkg.sv
// census_disparity_wta_pkg: shared widths and constants for the census stereo pipeline
package census_disparity_wta_pkg;
   localparam int CODE_WIDTH_DEF = 8;
   localparam int DISP_WIDTH_DEF = 4;
   localparam int COST_WIDTH_DEF = 4;
   localparam int MAX_DISP_DEF = 16;
   // Truncate to the cost width in use; any truncation of all-ones stays all-ones
   localparam logic [31:0] COST_MASKED = '1;
endpackage

// File: rtl/census_hamming_cost.sv
// census_hamming_cost: combinational Hamming distance between two census codes
module census_hamming_cost
   import census_disparity_wta_pkg::*;
#(
   parameter int CODE_WIDTH = CODE_WIDTH_DEF,
   parameter int COST_WIDTH = COST_WIDTH_DEF
) (
   input  logic [CODE_WIDTH-1:0] a,
   input  logic [CODE_WIDTH-1:0] b,
   output logic [COST_WIDTH-1:0] cost
);
   logic [CODE_WIDTH-1:0] x;
   assign x = a ^ b;
   always_comb begin
      cost = '0;
      for (int i = 0; i < CODE_WIDTH; i++) cost = cost + COST_WIDTH'(x[i]);
   end
endmodule

// File: rtl/census_disparity_wta.sv
// census_disparity_wta: per-pixel Hamming costs over a disparity range and winner-take-all selection
module census_disparity_wta
   import census_disparity_wta_pkg::*;
#(
   parameter int WIDTH      = 320,
   parameter int CODE_WIDTH = CODE_WIDTH_DEF,
   parameter int MAX_DISP   = MAX_DISP_DEF,
   parameter int DISP_WIDTH = DISP_WIDTH_DEF,
   parameter int COST_WIDTH = COST_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  code_valid,
   input  logic                  sof,
   input  logic [CODE_WIDTH-1:0] census_l,
   input  logic [CODE_WIDTH-1:0] census_r,
   output logic [DISP_WIDTH-1:0] disp_out,
   output logic [COST_WIDTH-1:0] cost_out,
   output logic                  edge_flag,
   output logic                  disp_valid
);
   localparam int COL_W = $clog2(WIDTH);
   localparam logic [COST_WIDTH-1:0] MASKED = COST_WIDTH'(COST_MASKED);

   logic [COL_W-1:0]      col, cur_col;
   logic [CODE_WIDTH-1:0] hist [MAX_DISP-1];
   logic [CODE_WIDTH-1:0] cand [MAX_DISP];
   logic [COST_WIDTH-1:0] raw [MAX_DISP];
   logic [COST_WIDTH-1:0] s1_cost [MAX_DISP];
   logic                  s1_valid, s1_edge;
   logic [DISP_WIDTH-1:0] best_d;
   logic [COST_WIDTH-1:0] best_c;

   assign cur_col = sof ? '0 : col;

   genvar d;
   generate
      for (d = 0; d < MAX_DISP; d++) begin : g_cand
         if (d == 0) begin : g_now
            assign cand[d] = census_r;
         end else begin : g_hist
            assign cand[d] = hist[d-1];
         end
         census_hamming_cost #(.CODE_WIDTH(CODE_WIDTH), .COST_WIDTH(COST_WIDTH)) u_cost (
            .a    (census_l),
            .b    (cand[d]),
            .cost (raw[d])
         );
      end
   endgenerate

   // Stale history from a previous row is never cleared; masking by column hides it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col      <= '0;
         s1_valid <= 1'b0;
         s1_edge  <= 1'b0;
         for (int k = 0; k < MAX_DISP-1; k++) hist[k] <= '0;
         for (int k = 0; k < MAX_DISP; k++) s1_cost[k] <= '0;
      end else begin
         s1_valid <= code_valid;
         if (code_valid) begin
            col     <= (cur_col == COL_W'(WIDTH-1)) ? '0 : cur_col + 1'b1;
            hist[0] <= census_r;
            for (int k = 1; k < MAX_DISP-1; k++) hist[k] <= hist[k-1];
            s1_edge <= cur_col < COL_W'(MAX_DISP-1);
            for (int k = 0; k < MAX_DISP; k++) s1_cost[k] <= (COL_W'(k) > cur_col) ? MASKED : raw[k];
         end
      end
   end

   // Strict less-than keeps the smallest disparity on ties
   always_comb begin
      best_d = '0;
      best_c = s1_cost[0];
      for (int k = 1; k < MAX_DISP; k++) begin
         best_d = (s1_cost[k] < best_c) ? DISP_WIDTH'(k) : best_d;
         best_c = (s1_cost[k] < best_c) ? s1_cost[k] : best_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp_out   <= '0;
         cost_out   <= '0;
         edge_flag  <= 1'b0;
         disp_valid <= 1'b0;
      end else begin
         disp_valid <= s1_valid;
         if (s1_valid) begin
            disp_out  <= best_d;
            cost_out  <= best_c;
            edge_flag <= s1_edge;
         end
      end
   end
endmodule

// File: tb/tb_census_disparity_wta.sv
// tb_census_disparity_wta: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_census_disparity_wta;
   logic       clk = 1'b0, rst_n = 1'b0, code_valid = 1'b0, sof = 1'b0;
   logic [7:0] census_l = '0, census_r = '0;
   logic [3:0] disp_out, cost_out;
   logic       edge_flag, disp_valid;

   typedef struct {
      int         cyc;
      logic [3:0] disp;
      logic [3:0] cost;
      logic       edg;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0, n_fail = 0;

   census_disparity_wta dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_valid (code_valid),
      .sof        (sof),
      .census_l   (census_l),
      .census_r   (census_r),
      .disp_out   (disp_out),
      .cost_out   (cost_out),
      .edge_flag  (edge_flag),
      .disp_valid (disp_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] u(input int x);
      return 8'(x * 37 + 11);
   endfunction

   task automatic px(input logic s, input logic [7:0] l, input logic [7:0] r, input int dexp, input int cexp, input logic eexp);
      @(negedge clk);
      code_valid = 1'b1;
      sof = s;
      census_l = l;
      census_r = r;
      q.push_back('{cyc + 2, 4'(dexp), 4'(cexp), eexp});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         code_valid = 1'b0;
         sof = 1'b0;
      end
   endtask

   task automatic chk_zero(input string nm);
      n_tests++;
      if ({disp_valid, disp_out, cost_out, edge_flag} !== 10'd0) begin
         n_fail++;
         $display("FAIL %s: valid=%b disp=%0d cost=%0d edge=%b, required all zero", nm, disp_valid, disp_out, cost_out, edge_flag);
      end
   endtask

   // Right code at x is u(x); left at x>=5 is u(x-5), so the true shift is 5
   task automatic shift_px(input int x);
      if (x == 0) px(1'b1, 8'hFF, u(0), 0, 5, 1'b1);
      else if (x < 5) px(1'b0, u(x), u(x), 0, 0, 1'b1);
      else px(1'b0, u(x - 5), u(x), 5, 0, x < 15);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() != 0 && q[0].cyc < cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL missing: output due at cycle %0d absent (now %0d)", q[0].cyc, cyc);
         void'(q.pop_front());
      end
      if (disp_valid) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected: disp_valid at cycle %0d disp=%0d cost=%0d", cyc, disp_out, cost_out);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.disp !== disp_out || e.cost !== cost_out || e.edg !== edge_flag) begin
               n_fail++;
               $display("FAIL result: got cyc=%0d disp=%0d cost=%0d edge=%b, required cyc=%0d disp=%0d cost=%0d edge=%b",
                        cyc, disp_out, cost_out, edge_flag, e.cyc, e.disp, e.cost, e.edg);
            end
         end
      end
   end

   initial begin
      int pat[5] = '{1, 0, 1, 1, 0};
      int k, x;
      repeat (3) begin
         @(negedge clk);
         chk_zero("reset_hold");
         code_valid = 1'b1;
         sof = 1'($urandom);
         census_l = 8'($urandom);
         census_r = 8'($urandom);
      end
      @(negedge clk);
      chk_zero("reset_hold");
      rst_n = 1'b1;
      code_valid = 1'b0;

      for (int i = 0; i < 64; i++) px(i == 0, 8'(i), 8'(i), 0, 0, i < 15);
      idle(3);

      for (int i = 0; i < 40; i++) shift_px(i);
      idle(3);

      for (int i = 0; i < 20; i++) px(i == 0, 8'h00, 8'h00, 0, 0, i < 15);
      for (int i = 0; i < 20; i++) px(i == 0, 8'hFF, 8'h00, 0, 8, i < 15);
      idle(3);

      k = 0;
      x = 0;
      while (x < 40) begin
         if (pat[k % 5] != 0) begin
            shift_px(x);
            x++;
         end else idle(1);
         k++;
      end
      idle(3);

      // History is all zero before the mid-row sof, so unmasked candidates would cost 0
      for (int i = 0; i < 100; i++) px(i == 0, 8'h00, 8'h00, 0, 0, i < 15);
      px(1'b1, 8'h00, 8'hFF, 0, 8, 1'b1);
      px(1'b0, 8'h00, 8'hF0, 0, 4, 1'b1);
      px(1'b0, 8'h00, 8'hFF, 1, 4, 1'b1);
      px(1'b0, 8'h00, 8'hFF, 2, 4, 1'b1);
      px(1'b0, 8'h00, 8'h00, 0, 0, 1'b1);

      @(negedge clk);
      code_valid = 1'b1;
      sof = 1'b0;
      census_l = 8'h33;
      census_r = 8'h55;
      @(negedge clk);
      rst_n = 1'b0;
      census_l = 8'($urandom);
      census_r = 8'($urandom);
      @(negedge clk);
      chk_zero("mid_reset");
      rst_n = 1'b1;
      code_valid = 1'b0;
      idle(2);
      px(1'b0, 8'h00, 8'h0F, 0, 4, 1'b1);
      px(1'b0, 8'h0F, 8'hAA, 1, 0, 1'b1);
      idle(5);

      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
